// File: rtl/iter_result_sink_pkg.sv
// iter_result_sink_pkg: run-length and FSM state encodings shared with the recurrence stage
package iter_result_sink_pkg;
    localparam int N_ITER_DEFAULT = 100;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/iter_result_fifo.sv
// iter_result_fifo: 2-entry FIFO with head at entry 0, simultaneous push/pop
module iter_result_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
    logic [1:0]   count_q, count_d, cp;
    logic         pop_ok, push_ok;
    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        cp      = count_q - {1'b0, pop_ok};
        count_d = cp + {1'b0, push_ok};
        mem0_d  = (push_ok && cp == 2'd0) ? din : (pop_ok ? mem1_q : mem0_q);
        mem1_d  = (push_ok && cp == 2'd1) ? din : mem1_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            mem0_q  <= '0;
            mem1_q  <= '0;
        end else begin
            count_q <= count_d;
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
        end
    end
    assign dout  = mem0_q;
    assign full  = count_q == 2'd2;
    assign empty = count_q == 2'd0;
endmodule

// File: rtl/iter_result_sink.sv
// iter_result_sink: tracks one upstream run of N_ITER iterations and queues its final iterate
module iter_result_sink
    import iter_result_sink_pkg::*;
#(
    parameter int W      = 32,
    parameter int N_ITER = N_ITER_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] y,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    output logic         drop
);
    localparam int CW = $clog2(N_ITER);
    localparam logic [CW-1:0] LAST = CW'(N_ITER - 1);
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_ovf_q, run_ovf_d, drop_q, drop_d;
    logic          push, full, empty;
    always_comb begin
        push      = state_q == RUN && cnt_q == LAST;
        state_d   = state_q == IDLE ? (start ? RUN : IDLE) : (push ? IDLE : RUN);
        cnt_d     = state_q == RUN ? cnt_q + CW'(1) : '0;
        // MSB set before the last iteration means the next doubling wraps
        run_ovf_d = state_q == RUN ? (run_ovf_q || (y[W-1] && cnt_q != LAST)) : 1'b0;
        drop_d    = drop_q || (push && full && !out_ready);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            run_ovf_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_ovf_q <= run_ovf_d;
            drop_q    <= drop_d;
        end
    end
    iter_result_fifo #(.W(W + 1)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({y, run_ovf_q}),
        .pop   (out_ready),
        .dout  ({out_data, out_ovf}),
        .full  (full),
        .empty (empty)
    );
    assign busy      = state_q == RUN;
    assign out_valid = !empty;
    assign drop      = drop_q;
endmodule

// File: tb/tb_iter_result_sink.sv
// tb_iter_result_sink: directed checks of run capture, overflow, buffering, drop and reset abort
module tb_iter_result_sink;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic [31:0] y = '0;
    logic        busy, out_valid, out_ovf, drop;
    logic [31:0] out_data;
    int tests = 0, fails = 0;

    iter_result_sink #(.W(32), .N_ITER(100)) dut (
        .clk(clk), .rst(rst), .start(start), .y(y), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse start, then feed 100 iterates; y=1 except the final iterate yv and 0x80000000 at ovf_k.
    // rdy_k raises out_ready for that cycle only, start_k re-pulses start, abort_k asserts rst.
    task automatic run(input logic [31:0] yv, input int ovf_k, input int rdy_k,
                       input int start_k, input int abort_k);
        logic keep_ready;
        keep_ready = out_ready;
        start = 1'b1;
        y     = 32'h1;
        tick();
        start = 1'b0;
        chk("busy_run", busy, 1);
        for (int k = 0; k < 100; k++) begin
            y         = (k == 99) ? yv : (k == ovf_k ? 32'h8000_0000 : 32'h1);
            start     = (k == start_k);
            rst       = (k == abort_k);
            out_ready = (k == rdy_k) ? 1'b1 : keep_ready;
            tick();
            start     = 1'b0;
            out_ready = keep_ready;
            if (k == abort_k) begin
                rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_drop", drop, 0);
        tick(3);
        chk("idle_stays", busy, 0);

        out_ready = 1'b1;
        run(32'h5, -1, -1, -1, -1);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 32'h5);
        chk("lat_ovf", out_ovf, 0);
        chk("lat_busy", busy, 0);
        tick();
        chk("lat_popped", out_valid, 0);

        out_ready = 1'b0;
        run(32'h7, 50, -1, -1, -1);
        chk("ovf_mid_data", out_data, 32'h7);
        chk("ovf_mid_flag", out_ovf, 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("ovf_mid_pop", out_valid, 0);
        run(32'h8000_0000, -1, -1, -1, -1);
        chk("ovf_last_data", out_data, 32'h8000_0000);
        chk("ovf_last_flag", out_ovf, 0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        run(32'h11, -1, -1, -1, -1);
        run(32'h22, -1, -1, -1, -1);
        chk("full_nodrop", drop, 0);
        run(32'h33, -1, -1, -1, -1);
        chk("full_drop", drop, 1);
        chk("full_head", out_data, 32'h11);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("full_second", out_data, 32'h22);
        chk("full_second_v", out_valid, 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("full_third_gone", out_valid, 0);
        chk("drop_sticky", drop, 1);

        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_drop_clr", drop, 0);
        run(32'hA1, -1, -1, -1, -1);
        run(32'hA2, -1, -1, -1, -1);
        run(32'hA3, -1, 99, -1, -1);
        chk("pp_drop", drop, 0);
        chk("pp_head", out_data, 32'hA2);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pp_tail", out_data, 32'hA3);
        chk("pp_tail_v", out_valid, 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pp_empty", out_valid, 0);

        run(32'hBB, -1, -1, -1, 40);
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        tick(120);
        chk("abort_noresult", out_valid, 0);

        run(32'h55, -1, -1, 20, -1);
        chk("restart_valid", out_valid, 1);
        chk("restart_data", out_data, 32'h55);
        chk("restart_busy", busy, 0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        tick(110);
        chk("restart_single", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/iter_result_sink.md
ITER_RESULT_SINK -- requirements
Module: iter_result_sink

Interface
REQ-001 Parameter: W, 32, data width of the iterated value.
REQ-002 Parameter: N_ITER, 100, iterations per run of the upstream recurrence stage.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse marking iteration 0 of an upstream run.
REQ-006 y  input  W  current iterate from the upstream recurrence stage (y = 2*y(n-1) + x).
REQ-007 busy  output  1  high while a run is being tracked.
REQ-008 out_valid  output  1  head result available.
REQ-009 out_ready  input  1  consumer accepts head result.
REQ-010 out_data  output  W  captured final iterate of the head result.
REQ-011 out_ovf  output  1  overflow flag of the head result.
REQ-012 drop  output  1  sticky: a completed result was discarded because the buffer was full.

Function
REQ-013 FSM states SHALL be IDLE and RUN; reset state IDLE.
REQ-014 IDLE with start=1 SHALL go to RUN next cycle with cnt=0 and run_ovf=0; start=0 SHALL stay IDLE.
REQ-015 In RUN, cnt SHALL increment by 1 per cycle; start SHALL be ignored.
REQ-016 In RUN with cnt=N_ITER-1, the block SHALL push {y, run_ovf} into the result buffer and return to IDLE next cycle.
REQ-017 Latency: start sampled in cycle t SHALL yield out_valid in cycle t+N_ITER+1 (buffer empty), out_data equal to y sampled in cycle t+N_ITER.
REQ-018 run_ovf SHALL set when y[W-1]=1 in any RUN cycle with cnt<=N_ITER-2 (next doubling wraps); sticky until next run start.
REQ-019 busy SHALL equal (state==RUN).
REQ-020 cnt width SHALL be ceil(log2(N_ITER)) bits; no wrap occurs since RUN exits at N_ITER-1.
REQ-021 Result buffer SHALL be 2 entries, first-in first-out; out_valid = not empty; out_data/out_ovf driven from head entry.
REQ-022 Pop SHALL occur when out_valid and out_ready are both 1 in the same cycle.
REQ-023 Push with buffer full and no pop SHALL discard the new result, leave contents unchanged, set drop=1.
REQ-024 Push and pop in the same cycle with buffer full SHALL succeed: head removed, new result appended, drop unchanged.
REQ-025 Push into empty buffer with out_ready=1 SHALL make out_valid visible next cycle (no combinational bypass).
REQ-026 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-027 rst=1 SHALL force state IDLE, cnt=0, run_ovf=0, buffer empty, drop=0 at the next edge, including mid-run (run aborted, no result pushed).
REQ-028 Outputs after reset: busy=0, out_valid=0, out_data=0, out_ovf=0, drop=0.
REQ-029 rst SHALL take priority over start and out_ready in the same cycle.

Structure
REQ-030 State encodings and default N_ITER SHALL reside in the shared header included by the recurrence stage, so both stages agree on run length.
REQ-031 The 2-entry buffer SHALL be a sub-module iter_result_fifo (width W+1, full/empty flags, simultaneous push/pop).
REQ-032 The FSM, counter and overflow tracking SHALL be in iter_result_sink itself.

Verification (W=32, N_ITER=100)
REQ-033 start at t=10, y=0x00000005 at t=110, out_ready=1 -> out_valid=1 at t=111, out_data=0x00000005, out_ovf=0, popped at t=111.
REQ-034 start, y=0x80000000 at RUN cnt=50, else 0x1 -> result out_ovf=1; y MSB set only at cnt=99 -> out_ovf=0.
REQ-035 Three consecutive runs, out_ready=0 -> two results held in order, drop=1 after third capture, third value absent after draining.
REQ-036 Buffer full, out_ready=1 in the capture cycle of a new run -> oldest popped, new appended, drop stays 0.
REQ-037 rst at RUN cnt=40 -> busy=0 next cycle, out_valid=0, no result ever appears for that run.
REQ-038 start pulsed again at RUN cnt=20 -> ignored; single result captured at cnt=99 of first run.
